// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing constants (visible, porches, sync widths).
//   - Derived defaults DEF_H_TOTAL / DEF_V_TOTAL.
//   - coord_t: 12-bit raster coordinate; span_t: one bit wider, so that a
//     full axis length of 4096 can be summed without overflow.
//   - axis_total(): sums the four region lengths of one axis.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   span_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  function automatic span_t axis_total(input coord_t vis, input coord_t front,
                                       input coord_t sync, input coord_t back);
    return span_t'(vis) + span_t'(front) + span_t'(sync) + span_t'(back);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis (horizontal or vertical). Counts 0..TOTAL-1 while enabled
//   and wraps to 0. Region flags are decoded from the next count and
//   registered, so they line up with count_o in the same cycle.
//
//   Ports
//     clk_i        pixel clock
//     rst_i        asynchronous, active-high reset (count -> TOTAL-1)
//     en_i         count enable
//     vis_len_i    visible region length
//     front_len_i  front porch length
//     sync_len_i   sync pulse length
//     back_len_i   back porch length
//     pol_i        active level of sync_o
//     count_o      current position on this axis
//     wrap_o       count_o is TOTAL-1 (next enabled edge returns to 0)
//     visible_o    count_o is inside the visible region
//     sync_o       pol_i inside the sync region, ~pol_i elsewhere
//
//   The length inputs are expected to be static (tied to constants).
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  coord_t vis_len_i,
  input  coord_t front_len_i,
  input  coord_t sync_len_i,
  input  coord_t back_len_i,
  input  logic   pol_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   visible_o,
  output logic   sync_o
);

  span_t  sync_start;
  span_t  sync_end;
  span_t  total;
  coord_t last;

  coord_t count_q, count_d;
  logic   visible_q, visible_d;
  logic   sync_q, sync_d;

  assign sync_start = span_t'(vis_len_i) + span_t'(front_len_i);
  assign sync_end   = sync_start + span_t'(sync_len_i);
  assign total      = axis_total(vis_len_i, front_len_i, sync_len_i, back_len_i);
  assign last       = coord_t'(total - span_t'(1));

  assign wrap_o = (count_q == last);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + coord_t'(1);
    end
    // Flags describe count_d so that, once registered, they match count_q.
    visible_d = (span_t'(count_d) < span_t'(vis_len_i));
    sync_d    = ((span_t'(count_d) >= sync_start) && (span_t'(count_d) < sync_end))
                ? pol_i : ~pol_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= last;
      visible_q <= 1'b0;
      sync_q    <= ~pol_i;
    end else begin
      count_q   <= count_d;
      visible_q <= visible_d;
      sync_q    <= sync_d;
    end
  end

  assign count_o   = count_q;
  assign visible_o = visible_q;
  assign sync_o    = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator: horizontal/vertical sync, blanking and pixel
//   coordinates for the VGA output register stage. Both axes are instances
//   of vga_axis_counter; the vertical axis advances on the horizontal wrap.
//
//   Ports
//     iPIXEL_CLK    pixel clock
//     iRST          asynchronous, active-high reset (position H_TOTAL-1, V_TOTAL-1)
//     oX, oY        current raster position
//     oREQ          (oX,oY) is inside the visible area
//     oHSYNC        HS_POL inside horizontal sync region
//     oVSYNC        VS_POL inside vertical sync region (depends on y only)
//     oBLANK_N      low outside the visible area
//     oSYNC_N       composite sync, unused, held at 1
//     oLINE_START   one-cycle pulse at x = 0
//     oFRAME_START  one-cycle pulse at (0,0)
//
//   Build option VGA_TIMING_LEAD_EN: oX, oY and oREQ lead oHSYNC, oVSYNC,
//   oBLANK_N, oLINE_START and oFRAME_START by one cycle, to cover a pixel
//   source with one cycle of read latency. Undefined: all outputs aligned.
//
//   Each axis total must not exceed 4096.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic        iPIXEL_CLK,
  input  logic        iRST,
  output logic [11:0] oX,
  output logic [11:0] oY,
  output logic        oREQ,
  output logic        oHSYNC,
  output logic        oVSYNC,
  output logic        oBLANK_N,
  output logic        oSYNC_N,
  output logic        oLINE_START,
  output logic        oFRAME_START
);

  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap;
  logic   h_vis, v_vis;
  logic   h_sync, v_sync;
  logic   req;

  vga_axis_counter u_h_axis (
    .clk_i       (iPIXEL_CLK),
    .rst_i       (iRST),
    .en_i        (1'b1),
    .vis_len_i   (coord_t'(H_VISIBLE)),
    .front_len_i (coord_t'(H_FRONT)),
    .sync_len_i  (coord_t'(H_SYNC)),
    .back_len_i  (coord_t'(H_BACK)),
    .pol_i       (HS_POL),
    .count_o     (h_cnt),
    .wrap_o      (h_wrap),
    .visible_o   (h_vis),
    .sync_o      (h_sync)
  );

  vga_axis_counter u_v_axis (
    .clk_i       (iPIXEL_CLK),
    .rst_i       (iRST),
    .en_i        (h_wrap),
    .vis_len_i   (coord_t'(V_VISIBLE)),
    .front_len_i (coord_t'(V_FRONT)),
    .sync_len_i  (coord_t'(V_SYNC)),
    .back_len_i  (coord_t'(V_BACK)),
    .pol_i       (VS_POL),
    .count_o     (v_cnt),
    .wrap_o      (v_wrap),
    .visible_o   (v_vis),
    .sync_o      (v_sync)
  );

  // A horizontal wrap now means x = 0 after the edge; with the vertical wrap
  // as well it means (0,0). Registering those gives pulses aligned to oX/oY.
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  assign line_start_d  = h_wrap;
  assign frame_start_d = h_wrap & v_wrap;

  always_ff @(posedge iPIXEL_CLK or posedge iRST) begin
    if (iRST) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Both visibility flags are already registered, so this is flop-to-port.
  assign req = h_vis & v_vis;

  assign oX      = h_cnt;
  assign oY      = v_cnt;
  assign oREQ    = req;
  assign oSYNC_N = 1'b1;

`ifdef VGA_TIMING_LEAD_EN
  // One extra register stage on the timing outputs; coordinates and oREQ
  // run one cycle ahead so a synchronous-RAM pixel source lines up.
  logic hsync_q, vsync_q, blank_n_q, line_start_dly_q, frame_start_dly_q;

  always_ff @(posedge iPIXEL_CLK or posedge iRST) begin
    if (iRST) begin
      hsync_q           <= ~HS_POL;
      vsync_q           <= ~VS_POL;
      blank_n_q         <= 1'b0;
      line_start_dly_q  <= 1'b0;
      frame_start_dly_q <= 1'b0;
    end else begin
      hsync_q           <= h_sync;
      vsync_q           <= v_sync;
      blank_n_q         <= req;
      line_start_dly_q  <= line_start_q;
      frame_start_dly_q <= frame_start_q;
    end
  end

  assign oHSYNC       = hsync_q;
  assign oVSYNC       = vsync_q;
  assign oBLANK_N     = blank_n_q;
  assign oLINE_START  = line_start_dly_q;
  assign oFRAME_START = frame_start_dly_q;
`else
  assign oHSYNC       = h_sync;
  assign oVSYNC       = v_sync;
  assign oBLANK_N     = req;
  assign oLINE_START  = line_start_q;
  assign oFRAME_START = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen. Horizontal timing is the 640x480
//   default; vertical timing is shortened (12 visible, 2 front, 2 sync,
//   3 back = 19 lines) so whole frames fit in a short run. Vertical sync is
//   therefore at y = 14..15 and the frame is 800*19 = 15200 cycles.
//   Expected values are addressed by (segment, edges since reset release).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] oX, oY;
  logic        oREQ, oHSYNC, oVSYNC, oBLANK_N, oSYNC_N, oLINE_START, oFRAME_START;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(12),  .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3),
    .HS_POL(1'b0),   .VS_POL(1'b0)
  ) dut (
    .iPIXEL_CLK   (clk),
    .iRST         (rst),
    .oX           (oX),
    .oY           (oY),
    .oREQ         (oREQ),
    .oHSYNC       (oHSYNC),
    .oVSYNC       (oVSYNC),
    .oBLANK_N     (oBLANK_N),
    .oSYNC_N      (oSYNC_N),
    .oLINE_START  (oLINE_START),
    .oFRAME_START (oFRAME_START)
  );

`ifdef VGA_TIMING_LEAD_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  typedef struct {
    int    seg;
    int    cyc;
    string nm;
    int    exp;
  } item_t;

  item_t sbq[$];
  int seg = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int hs_low = 0;
  int vs_low = 0;
  int fs_last = -1;
  int fs_prev = -1;

  // Edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic expect_at(input int s, input int c, input string n, input int v);
    item_t it;
    int i;
    it.seg = s; it.cyc = c; it.nm = n; it.exp = v;
    i = sbq.size();
    while (i > 0 && (sbq[i-1].seg > s || (sbq[i-1].seg == s && sbq[i-1].cyc > c))) i--;
    sbq.insert(i, it);
  endtask

  task automatic expect_reset(input int s);
    expect_at(s, 0, "x", 799);
    expect_at(s, 0, "y", 18);
    expect_at(s, 0, "req", 0);
    expect_at(s, 0, "blank", 0);
    expect_at(s, 0, "hs", 1);
    expect_at(s, 0, "vs", 1);
    expect_at(s, 0, "sync", 1);
    expect_at(s, 0, "ls", 0);
    expect_at(s, 0, "fs", 0);
  endtask

  function automatic int sig(input string n);
    case (n)
      "x":     return int'(oX);
      "y":     return int'(oY);
      "req":   return int'(oREQ);
      "blank": return int'(oBLANK_N);
      "hs":    return int'(oHSYNC);
      "vs":    return int'(oVSYNC);
      "sync":  return int'(oSYNC_N);
      "ls":    return int'(oLINE_START);
      "fs":    return int'(oFRAME_START);
      "hslow": return hs_low;
      "vslow": return vs_low;
      "fsgap": return fs_last - fs_prev;
      default: return -1;
    endcase
  endfunction

  // Monitor: samples on the falling edge, pops every item due by now.
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 &&
             (sbq[0].seg < seg || (sbq[0].seg == seg && sbq[0].cyc <= cyc))) begin
        item_t it;
        int    got;
        it = sbq.pop_front();
        total++;
        if (it.seg != seg || it.cyc != cyc) begin
          bad++;
          $display("FAIL missed_%s seg=%0d cyc=%0d (now seg=%0d cyc=%0d) required=%0d",
                   it.nm, it.seg, it.cyc, seg, cyc, it.exp);
        end else begin
          got = sig(it.nm);
          if (got != it.exp) begin
            bad++;
            $display("FAIL %s seg=%0d cyc=%0d actual=%0d required=%0d",
                     it.nm, seg, cyc, got, it.exp);
          end
        end
      end
      if (seg == 0 && !rst && cyc >= 1 && cyc <= 800 && oHSYNC == 1'b0) hs_low++;
      if (seg == 0 && !rst && cyc >= 1 && cyc <= 15200 && oVSYNC == 1'b0) vs_low++;
      if (seg == 0 && !rst && oFRAME_START) begin
        fs_prev = fs_last;
        fs_last = cyc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 60000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    seg = 0;

    // Reset state, then first edge after release.
    expect_reset(0);
    expect_at(0, 1, "x", 0);
    expect_at(0, 1, "y", 0);
    expect_at(0, 1, "req", 1);
    expect_at(0, 1, "sync", 1);
    expect_at(0, L, "blank", 0);
    expect_at(0, 1 + L, "blank", 1);
    expect_at(0, 1 + L, "ls", 1);
    expect_at(0, 1 + L, "fs", 1);
    expect_at(0, 1 + L, "hs", 1);
    expect_at(0, 2, "x", 1);
    expect_at(0, 2 + L, "ls", 0);
    expect_at(0, 2 + L, "fs", 0);

    // Blanking edge at x = 640.
    expect_at(0, 640, "x", 639);
    expect_at(0, 640, "req", 1);
    expect_at(0, 640 + L, "blank", 1);
    expect_at(0, 641, "x", 640);
    expect_at(0, 641, "req", 0);
    expect_at(0, 641 + L, "blank", 0);

    // Horizontal sync x = 656..751.
    expect_at(0, 656, "x", 655);
    expect_at(0, 656 + L, "hs", 1);
    expect_at(0, 657, "x", 656);
    expect_at(0, 657 + L, "hs", 0);
    expect_at(0, 752 + L, "hs", 0);
    expect_at(0, 753, "x", 752);
    expect_at(0, 753 + L, "hs", 1);
    expect_at(0, 801, "hslow", 96);
    expect_at(0, 801, "x", 0);
    expect_at(0, 801, "y", 1);

    // Line wrap (799,10) -> (0,11).
    expect_at(0, 8800, "x", 799);
    expect_at(0, 8800, "y", 10);
    expect_at(0, 8800 + L, "ls", 0);
    expect_at(0, 8801, "x", 0);
    expect_at(0, 8801, "y", 11);
    expect_at(0, 8801, "req", 1);
    expect_at(0, 8801 + L, "ls", 1);
    expect_at(0, 8801 + L, "fs", 0);

    // First non-visible line.
    expect_at(0, 9601, "y", 12);
    expect_at(0, 9601, "req", 0);
    expect_at(0, 9601 + L, "blank", 0);

    // Vertical sync y = 14..15.
    expect_at(0, 11200, "y", 13);
    expect_at(0, 11200 + L, "vs", 1);
    expect_at(0, 11201, "y", 14);
    expect_at(0, 11201 + L, "vs", 0);
    expect_at(0, 12800, "y", 15);
    expect_at(0, 12800 + L, "vs", 0);
    expect_at(0, 12801, "y", 16);
    expect_at(0, 12801 + L, "vs", 1);

    // Frame wrap (799,18) -> (0,0).
    expect_at(0, 15200, "x", 799);
    expect_at(0, 15200, "y", 18);
    expect_at(0, 15200 + L, "fs", 0);
    expect_at(0, 15201, "x", 0);
    expect_at(0, 15201, "y", 0);
    expect_at(0, 15201, "req", 1);
    expect_at(0, 15201 + L, "fs", 1);
    expect_at(0, 15201, "vslow", 1600);
    expect_at(0, 15300, "fsgap", 15200);

    // Just before the mid-frame reset at (300,10) of the second frame.
    expect_at(0, 23500, "x", 299);
    expect_at(0, 23500, "y", 10);
    expect_at(0, 23500, "req", 1);
    expect_at(0, 23500 + L, "blank", 1);

    // After mid-frame reset and restart.
    expect_reset(1);
    expect_at(1, 1, "x", 0);
    expect_at(1, 1, "y", 0);
    expect_at(1, 1, "req", 1);
    expect_at(1, 1 + L, "fs", 1);
    expect_at(1, 1 + L, "blank", 1);
    expect_at(1, 801, "x", 0);
    expect_at(1, 801, "y", 1);
    expect_at(1, 801 + L, "ls", 1);
    expect_at(1, 801 + L, "fs", 0);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    wait_cyc(23500);
    @(posedge clk);
    #2;
    seg = 1;
    rst = 1'b1;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    wait_cyc(810);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL leftover actual=%0d required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that produces the horizontal/vertical sync, blanking and pixel-coordinate stream consumed by the VGA output register stage. It runs on the pixel clock, counts the full horizontal and vertical raster including porches and sync pulses, and tells the pixel source which coordinate to supply. It sits upstream of the VGA output stage: its sync/blank outputs drive that stage's sync, blank and composite-sync inputs, and its coordinates drive the frame-buffer or pattern logic that supplies R/G/B.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of oHSYNC (0 = active-low)
- VS_POL, 0, active level of oVSYNC (0 = active-low)

- iPIXEL_CLK  input  1  pixel clock; the only clock
- iRST  input  1  asynchronous, active-high reset
- oX  output  12  current horizontal count, 0..H_TOTAL-1
- oY  output  12  current vertical count, 0..V_TOTAL-1
- oREQ  output  1  pixel request: (oX,oY) is inside the visible area
- oHSYNC  output  1  horizontal sync at HS_POL when active
- oVSYNC  output  1  vertical sync at VS_POL when active
- oBLANK_N  output  1  low outside the visible area
- oSYNC_N  output  1  composite sync; held at 1 (unused)
- oLINE_START  output  1  one-cycle pulse when oX = 0
- oFRAME_START  output  1  one-cycle pulse when oX = 0 and oY = 0

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 default); V_TOTAL likewise (525 default). Both must be ≤ 4096.
- Horizontal counter increments every clock and wraps H_TOTAL-1 → 0. The vertical counter increments only on that wrap and wraps V_TOTAL-1 → 0 on the same edge as the horizontal wrap.
- Horizontal regions: visible 0..H_VISIBLE-1, front porch through H_VISIBLE+H_FRONT-1, sync through H_VISIBLE+H_FRONT+H_SYNC-1, back porch to H_TOTAL-1. Default sync spans x = 656..751. Vertical regions follow the same pattern; default sync spans y = 490..491.
- oHSYNC = HS_POL inside the horizontal sync region, otherwise ~HS_POL. oVSYNC = VS_POL inside the vertical sync region, otherwise ~VS_POL. oVSYNC depends only on y.
- oBLANK_N = 1 iff x < H_VISIBLE and y < V_VISIBLE. oREQ has the same decode.
- All outputs are registered; there are no combinational paths from counters to ports.

## Timing
- Reset state is position (H_TOTAL-1, V_TOTAL-1). Reset values: oX = 799, oY = 524, oREQ = 0, oBLANK_N = 0, oHSYNC = ~HS_POL, oVSYNC = ~VS_POL, oSYNC_N = 1, oLINE_START = 0, oFRAME_START = 0.
- First rising edge after iRST falls: position (0,0), oREQ = 1, oBLANK_N = 1, oLINE_START = 1, oFRAME_START = 1.
- Every output reflects the position shown on oX/oY in the same cycle; latency from counter to sync/blank is 0.
- Asserting iRST mid-frame returns all outputs to their reset values immediately, without waiting for a clock edge. No partial line or frame completes.
- Line period is exactly H_TOTAL cycles; frame period is exactly H_TOTAL × V_TOTAL cycles (420000 at defaults).

## Configuration
- VGA_TIMING_LEAD_EN defined: oX, oY and oREQ lead oHSYNC, oVSYNC, oBLANK_N, oLINE_START and oFRAME_START by one cycle. This aligns a pixel source with one-cycle read latency (synchronous RAM) with the output stage. The delayed outputs reset to the same inactive values listed above. The first edge after reset gives oX = 0, oY = 0, oREQ = 1, with oBLANK_N = 0. oBLANK_N, oLINE_START and oFRAME_START rise one edge later.
- VGA_TIMING_LEAD_EN undefined: all outputs are aligned as described in Timing.

## Structure
- Shared package vga_pkg holds the default 640×480@60 timing constants, the derived H_TOTAL and V_TOTAL, and the 12-bit coordinate type.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). Its inputs are count enable, region lengths and sync polarity. Its outputs are count, wrap, visible and sync.

## Test plan
- Hold iRST high, then release it: all outputs match the reset values. On the first edge: (0,0), oFRAME_START = 1, oREQ = 1.
- Run one line: oHSYNC = 0 for exactly 96 cycles, starting at x = 656. oBLANK_N falls at x = 640.
- Line wrap: at x = 799, y = 10 → next edge gives x = 0, y = 11, oLINE_START = 1, oFRAME_START = 0.
- Full frame: oVSYNC = 0 only for y = 490..491. Wrap (799,524) → (0,0) with oFRAME_START = 1. Exactly 420000 cycles between oFRAME_START pulses.
- Assert iRST at (300,200): outputs return to (799,524) with sync/blank inactive before the next edge. Normal restart follows release.
- Build with VGA_TIMING_LEAD_EN: oREQ rises one cycle before oBLANK_N. oHSYNC falls one cycle after oX = 656.
